// File: rtl/morse_blinker.sv
// Morse letter blinker: sends one of J..Q as a unit-timed on/off pattern on led,
// optionally repeating with an off gap. Repeat request port is `rpt` (`repeat` is a keyword).
module morse_blinker #(
   parameter int unsigned DIV   = 25000000,
   parameter int unsigned PAT_W = 14,
   parameter int unsigned GAP   = 3
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [2:0] letter,
   input  logic       start,
   input  logic       stop,
   input  logic       rpt,
   output logic       led,
   output logic       busy,
   output logic       done
);

   localparam int unsigned UW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned BW = $clog2(PAT_W);
   localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [UW-1:0] UNIT_LAST = UW'(DIV - 1);
   localparam logic [BW-1:0] BIT_TOP   = BW'(PAT_W - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(GAP - 1);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

   state_t            st, st_n;
   logic [PAT_W-1:0]  sh, sh_n;
   logic [UW-1:0]     ucnt, ucnt_n;
   logic [BW-1:0]     bcnt, bcnt_n;
   logic [GW-1:0]     gcnt, gcnt_n;
   logic [2:0]        let_q, let_n;
   logic              led_n, done_n;
   logic              unit_end;

   function automatic logic [PAT_W-1:0] pattern(input logic [2:0] l);
      logic [13:0]      p;
      logic [PAT_W-1:0] r;
      case (l)
         3'd0: p = 14'b01011101110111;
         3'd1: p = 14'b01110101110000;
         3'd2: p = 14'b01011101010000;
         3'd3: p = 14'b01110111000000;
         3'd4: p = 14'b01110100000000;
         3'd5: p = 14'b01110111011100;
         3'd6: p = 14'b01011101110100;
         3'd7: p = 14'b01110111010111;
      endcase
      r = '0;
      r[PAT_W-1 -: 14] = p;
      return r;
   endfunction

   assign unit_end = (ucnt == UNIT_LAST);
   assign busy     = (st != S_IDLE);

   always_ff @(posedge clock) begin
      if (reset) begin
         st    <= S_IDLE;
         sh    <= '0;
         ucnt  <= '0;
         bcnt  <= '0;
         gcnt  <= '0;
         let_q <= '0;
         led   <= 1'b0;
         done  <= 1'b0;
      end else begin
         st    <= st_n;
         sh    <= sh_n;
         ucnt  <= ucnt_n;
         bcnt  <= bcnt_n;
         gcnt  <= gcnt_n;
         let_q <= let_n;
         led   <= led_n;
         done  <= done_n;
      end
   end

   always_comb begin
      st_n   = st;
      sh_n   = sh;
      ucnt_n = ucnt;
      bcnt_n = bcnt;
      gcnt_n = gcnt;
      let_n  = let_q;
      led_n  = led;
      done_n = 1'b0;
      case (st)
         S_IDLE: begin
            if (start && !stop) begin
               let_n  = letter;
               sh_n   = pattern(letter);
               led_n  = sh_n[PAT_W-1];
               ucnt_n = '0;
               bcnt_n = BIT_TOP;
               st_n   = S_SEND;
            end
         end
         S_SEND: begin
            if (stop) begin
               st_n = S_IDLE;  sh_n = '0;  ucnt_n = '0;  bcnt_n = '0;  gcnt_n = '0;  led_n = 1'b0;
            end else if (!unit_end) begin
               ucnt_n = ucnt + 1'b1;
            end else begin
               ucnt_n = '0;
               if (bcnt == '0) begin
                  led_n = 1'b0;
                  if (rpt) begin
                     gcnt_n = '0;
                     st_n   = S_GAP;
                  end else begin
                     done_n = 1'b1;
                     st_n   = S_IDLE;
                  end
               end else begin
                  sh_n   = sh << 1;
                  led_n  = sh[PAT_W-2];
                  bcnt_n = bcnt - 1'b1;
               end
            end
         end
         S_GAP: begin
            // repeat is not looked at here: once in the gap, the reload is committed
            if (stop) begin
               st_n = S_IDLE;  sh_n = '0;  ucnt_n = '0;  bcnt_n = '0;  gcnt_n = '0;  led_n = 1'b0;
            end else if (!unit_end) begin
               ucnt_n = ucnt + 1'b1;
            end else begin
               ucnt_n = '0;
               if (gcnt == GAP_LAST) begin
                  sh_n   = pattern(let_q);
                  led_n  = sh_n[PAT_W-1];
                  bcnt_n = BIT_TOP;
                  gcnt_n = '0;
                  st_n   = S_SEND;
               end else begin
                  gcnt_n = gcnt + 1'b1;
               end
            end
         end
         default: st_n = S_IDLE;
      endcase
   end

endmodule

// File: doc/morse_blinker.md
MORSE_BLINKER -- requirements
Module: morse_blinker

Interface
REQ-001 The block SHALL have parameter DIV, default 25000000: clock cycles per Morse unit; legal range is DIV >= 1.
REQ-002 The block SHALL have parameter PAT_W, default 14: pattern length in units; legal range is PAT_W >= 14.
REQ-003 The block SHALL have parameter GAP, default 3: off units between repeated passes; legal range is GAP >= 1.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port letter, input, 3 bits: letter select, 0..7 = J,K,L,M,N,O,P,Q.
REQ-007 The block SHALL have port start, input, 1 bit: request to transmit the selected letter.
REQ-008 The block SHALL have port stop, input, 1 bit: abort the current transmission.
REQ-009 The block SHALL have port repeat, input, 1 bit: retransmit continuously while high.
REQ-010 The block SHALL have port led, output, 1 bit: registered light output; 1 = on.
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse at normal completion.

Function
REQ-013 The 14-bit patterns, sent MSB first, SHALL be:
- J = 01011101110111
- K = 01110101110000
- L = 01011101010000
- M = 01110111000000
- N = 01110100000000
- O = 01110111011100
- P = 01011101110100
- Q = 01110111010111
REQ-014 When PAT_W > 14, each pattern SHALL be left-aligned and zero-padded in the LSBs.
REQ-015 The state machine SHALL have exactly the states IDLE, SEND and GAP.
REQ-016 IDLE with start=1 and stop=0 at a clock edge SHALL load the following at that edge:
- letter latched
- shift register = pattern
- led = pattern MSB
- unit counter = 0
- bit counter = PAT_W-1
- state = SEND
REQ-017 In SEND, each bit SHALL be held on led for exactly DIV cycles; when the unit counter reaches DIV-1, the shift register SHALL shift left, led SHALL take the next bit and the bit counter SHALL decrement.
REQ-018 A full pass SHALL last exactly PAT_W*DIV cycles, measured from the first SEND cycle.
REQ-019 At the end of the final unit, with repeat=0 sampled on that edge, the block SHALL go to IDLE, set led=0 and pulse done=1 for exactly one cycle (the first IDLE cycle).
REQ-020 At the end of the final unit, with repeat=1 sampled on that edge, the block SHALL go to GAP with led=0 for GAP*DIV cycles, then reload the latched letter's pattern and re-enter SEND, with no done pulse.
REQ-021 In GAP, repeat SHALL NOT be re-sampled; the reload always occurs.
REQ-022 start SHALL be ignored while busy=1.
REQ-023 letter changes after the latch SHALL be ignored until the next accepted start.
REQ-024 stop=1 in SEND or GAP SHALL, at the next edge, force IDLE, led=0 and clear all counters, with no done pulse.
REQ-025 stop=1 together with start=1 in IDLE: stop SHALL win, and the start SHALL be dropped.
REQ-026 With DIV=1, each unit SHALL last exactly one cycle, and the counter SHALL never exceed 0.
REQ-027 The unit counter width SHALL be sized from DIV and SHALL never wrap past DIV-1.
REQ-028 The bit counter SHALL be sized from PAT_W.

Reset
REQ-029 reset=1 at an edge SHALL set state=IDLE, led=0, busy=0 and done=0, and SHALL clear the shift register, counters and latched letter, regardless of state.
REQ-030 reset SHALL take priority over start, stop and repeat.
REQ-031 A mid-transmission reset SHALL NOT produce a done pulse.

Verification
REQ-032 The bench SHALL cover, with DIV=2, PAT_W=14 and GAP=3, the following directed scenarios:
- reset held 3 cycles, then released -> led=0, busy=0, done=0; no activity without start.
- letter=4 (N), 1-cycle start -> led per cycle = 00 111111 00 11 0000000000000000 (28 cycles); busy high for those 28 cycles; done=1 on cycle 29 only.
- letter=3 (M), repeat=1 held -> 28 pass cycles, 6 cycles led=0, identical pass repeated; drop repeat in 2nd pass -> that pass completes, then done pulse.
- start re-pulsed with letter=7 at cycle 10 of an N pass -> ignored; N pattern unchanged; busy unchanged.
- stop at cycle 5 of a K pass -> next cycle led=0, busy=0; done never asserts.
- reset at cycle 9 of a Q pass with repeat=1 -> next cycle all outputs 0; no done; a fresh start then runs normally.
- PAT_W=16, letter=0 (J) -> 32-cycle pass whose last 4 cycles are led=0.
